// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-beat AXI responder backed by a word-addressed RAM.
// Read (AR/R) and write (AW/W/B) channels are served by two independent
// FSMs, each with at most one transaction in flight. Every response is
// delayed by a programmable number of cycles (RD_DELAY / WR_DELAY).
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where both valid and ready are high. A source holds valid and its payload
// steady until that edge; this block never withdraws rvalid/bvalid or
// changes rid/rdata/rresp/rlast or bid/bresp before the matching ready.
//
// Word index = addr[ADDR_W+1:2]; upper address bits are ignored so the
// address space wraps. Only single-beat transfers are supported: a nonzero
// arlen/awlen is answered with SLVERR (reads still return one beat, writes
// are suppressed). rd_state / wr_state expose the FSM states for debug.

module axi_ram_slave #(
   parameter int ADDR_W   = 10,
   parameter int RD_DELAY = 2,
   parameter int WR_DELAY = 2
) (
   input  logic        clk,
   input  logic        reset,

   // read address channel
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,

   // read data channel
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,

   // write address channel
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,

   // write data channel
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,

   // write response channel
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,

   // debug view of the FSM states (0 = IDLE, 1 = WAIT, 2 = RESP)
   output logic [1:0]  rd_state,
   output logic [1:0]  wr_state
);

   localparam int         DEPTH    = 2 ** ADDR_W;
   localparam logic [1:0] RESP_OK  = 2'b00;
   localparam logic [1:0] RESP_ERR = 2'b10;
   localparam logic [3:0] RD_LOAD  = 4'(RD_DELAY - 1);
   localparam logic [3:0] WR_LOAD  = 4'(WR_DELAY - 1);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_WAIT = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   // storage; contents are deliberately not reset
   logic [31:0] mem [0:DEPTH-1];

   // read-side state
   r_state_t          r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_idx;
   logic [3:0]        r_id;
   logic              r_err;

   // write-side state
   w_state_t          w_state;
   logic [3:0]        w_cnt;
   logic [ADDR_W-1:0] w_idx;
   logic [3:0]        w_id;
   logic              w_err;
   logic [31:0]       w_data;
   logic [3:0]        w_strb;

   logic ar_hs;
   logic aw_hs;
   logic w_hs;
   logic aw_have;
   logic w_have;
   logic wr_commit;

   assign ar_hs = arvalid && arready;
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // In W_IDLE a low ready means that channel was already captured earlier.
   assign aw_have = aw_hs || !awready;
   assign w_have  = w_hs || !wready;

   // RAM is written on the last WAIT cycle unless the burst was rejected.
   assign wr_commit = (w_state == W_WAIT) && (w_cnt == 4'd0) && !w_err;

   assign rd_state = r_state;
   assign wr_state = w_state;

   // Fields the responder does not interpret.
   logic unused_inputs;
   assign unused_inputs = ^{arsize, awsize, wlast,
                            araddr[31:ADDR_W+2], araddr[1:0],
                            awaddr[31:ADDR_W+2], awaddr[1:0]};

   // Read FSM: accept AR, wait RD_DELAY cycles, present one beat until rready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= R_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_id    <= 4'd0;
         r_err   <= 1'b0;
         arready <= 1'b1;
         rvalid  <= 1'b0;
         rid     <= 4'd0;
         rdata   <= 32'd0;
         rresp   <= RESP_OK;
         rlast   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_id    <= arid;
                  r_idx   <= araddr[ADDR_W+1:2];
                  r_err   <= (arlen != 8'd0);
                  r_cnt   <= RD_LOAD;
                  arready <= 1'b0;
                  r_state <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_cnt == 4'd0) begin
                  // A same-cycle write commit lands after this sample.
                  rdata   <= mem[r_idx];
                  rid     <= r_id;
                  rresp   <= r_err ? RESP_ERR : RESP_OK;
                  rlast   <= 1'b1;
                  rvalid  <= 1'b1;
                  r_state <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
                  arready <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: begin
               rvalid  <= 1'b0;
               rlast   <= 1'b0;
               arready <= 1'b1;
               r_state <= R_IDLE;
            end
         endcase
      end
   end

   // Write FSM: capture AW and W in any order, wait WR_DELAY cycles, commit, respond.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_cnt   <= 4'd0;
         w_idx   <= '0;
         w_id    <= 4'd0;
         w_err   <= 1'b0;
         w_data  <= 32'd0;
         w_strb  <= 4'd0;
         awready <= 1'b1;
         wready  <= 1'b1;
         bvalid  <= 1'b0;
         bid     <= 4'd0;
         bresp   <= RESP_OK;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  w_id    <= awid;
                  w_idx   <= awaddr[ADDR_W+1:2];
                  w_err   <= (awlen != 8'd0);
                  awready <= 1'b0;
               end
               if (w_hs) begin
                  w_data <= wdata;
                  w_strb <= wstrb;
                  wready <= 1'b0;
               end
               if (aw_have && w_have) begin
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  w_cnt   <= WR_LOAD;
                  w_state <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (w_cnt == 4'd0) begin
                  bid     <= w_id;
                  bresp   <= w_err ? RESP_ERR : RESP_OK;
                  bvalid  <= 1'b1;
                  w_state <= W_RESP;
               end else begin
                  w_cnt <= w_cnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  awready <= 1'b1;
                  wready  <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: begin
               bvalid  <= 1'b0;
               awready <= 1'b1;
               wready  <= 1'b1;
               w_state <= W_IDLE;
            end
         endcase
      end
   end

   // RAM write port: byte-merge the captured data under its strobes.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb[i]) begin
               mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
- Single-beat AXI responder backed by an internal word-addressed RAM.
- Sits at the slave end of the CPU's AXI master bridge. Used as the bench memory model and as on-chip scratch RAM.
- Read channel (AR/R) and write channel (AW/W/B) run as independent FSMs. Each FSM has at most one transaction outstanding.
- Every response waits a programmable latency.

Parameters:
- ADDR_W, 10, RAM index width; depth = 2^ADDR_W 32-bit words.
- RD_DELAY, 2, cycles from AR handshake to rvalid assertion; valid range 1..15.
- WR_DELAY, 2, cycles from capture of both AW and W to bvalid assertion; valid range 1..15.

Ports:
- clk in 1: single clock; all state updates on its rising edge.
- reset in 1: asynchronous, active-high.
- arid in 4, araddr in 32, arlen in 8, arsize in 3, arvalid in 1, arready out 1.
- rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
- awid in 4, awaddr in 32, awlen in 8, awsize in 3, awvalid in 1, awready out 1.
- wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
- bid out 4, bresp out 2, bvalid out 1, bready in 1.
- arburst, arlock, arcache, arprot, awburst, awlock, awcache, awprot and wid are not port members; masters tie them off.

Behaviour:
- Reset values: arready=1, awready=1, wready=1. rvalid=0, bvalid=0, rid/bid=0, rresp/bresp=0, rdata=0, rlast=0. Both FSMs in IDLE. RAM contents are not reset.
- Word index = addr[ADDR_W+1:2]. Higher address bits are ignored, so the address space wraps. Low two address bits and arsize/awsize do not alter the index.
- Read FSM states: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: arready=1. On arvalid&&arready, latch arid and the index, load the counter with RD_DELAY-1, go to R_WAIT. arready drops the next cycle.
  - R_WAIT: counter decrements each cycle. At 0, latch rdata from the RAM and go to R_RESP.
  - R_RESP: rvalid=1, rlast=1, rid = latched id.
  - rresp=2'b00 (OKAY) when latched arlen==0; otherwise 2'b10 (SLVERR), with the single beat still returned and rlast=1.
  - rid/rdata/rresp hold stable until rready. On rvalid&&rready, go to R_IDLE with arready=1 the following cycle.
  - Total latency with RD_DELAY=2: AR handshake at cycle N gives rvalid at N+2.
- Write FSM states: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: awready and wready are each deasserted individually once their own handshake completes. AW-first, W-first and simultaneous arrival are all legal.
  - Once both are captured, load the counter with WR_DELAY-1 and go to W_WAIT.
  - W_WAIT: at counter 0, perform the RAM write, merging bytes where wstrb[i]=1. If latched awlen!=0, do not write and set bresp=SLVERR. Go to W_RESP.
  - W_RESP: bvalid=1, bid = latched awid. Hold until bready. On bvalid&&bready, go to W_IDLE with awready=wready=1 the next cycle.
- Read/write collision: if the read RAM sample and the write commit occur in the same cycle at the same index, the read returns pre-write data.
- Reset asserted mid-transaction: both FSMs go to IDLE immediately. Any pending response is dropped. A pending write that has not yet committed is discarded.
- wlast is ignored. A beat is treated as last regardless.

Test Plan:
- Write then read, awaddr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, awid=3:
  - Expected: bvalid 2 cycles after the later of the AW/W handshakes, bid=3, bresp=0.
  - Then read araddr=0x100, arid=5. Expected: rvalid 2 cycles after the AR handshake, rdata=0xDEADBEEF, rid=5, rlast=1, rresp=0.
- Byte strobe:
  - Write 0x11223344 to 0x20, then 0xAABBCCDD to 0x20 with wstrb=4'b0100.
  - Expected read of 0x20: 0x11BB3344.
- Handshake order:
  - W presented 3 cycles before AW. Expected: wready low after its handshake, no bvalid until AW is accepted, then bvalid WR_DELAY cycles later.
  - Repeat with AW and W in the same cycle; the result must be identical.
- Backpressure:
  - Hold rready=0 for 5 cycles after rvalid. Expected: rvalid/rdata/rid stable throughout, arready=0 throughout.
  - Release rready. Expected: arready=1 the next cycle.
  - Same test on B with bready.
- Burst error and wrap (ADDR_W=10):
  - arlen=1 expected: single beat with rresp=2'b10, rlast=1.
  - Write to 0x1000_0004 and read from 0x0000_0004 expected: same data.
- Async reset:
  - Assert reset during R_WAIT and during W_WAIT, without a clock edge. Expected: rvalid=bvalid=0 and arready=awready=wready=1 immediately.
  - Expected after reset: the discarded write is not visible on a subsequent read.
